// File: rtl/interval_timer_pkg.sv
// Shared types and default constants for the programmable interval timer.
// Contents: timer state enum, default WIDTH/PERIOD/HCW, system clock rate.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 29;
    localparam int DEF_PERIOD = 500_000_000;
    localparam int DEF_HCW    = 8;
    localparam int CLK_HZ     = 100_000_000;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the reflex FSM, the timer and the display.
// master: drives start/stop/clear/enable/oneshot/load/term_in, reads status.
// slave : the timer; drives count/running/hit/done (+hit_count when
//         INTERVAL_TIMER_HITCNT_EN is defined).
interface interval_timer_if import timer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
`ifdef INTERVAL_TIMER_HITCNT_EN
    ,
    parameter int HCW   = DEF_HCW
`endif
) ();

    logic             start;
    logic             stop;
    logic             clear;
    logic             enable;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] term_in;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             hit;
    logic             done;
`ifdef INTERVAL_TIMER_HITCNT_EN
    logic [HCW-1:0]   hit_count;
`endif

    modport master (
        output start, stop, clear, enable, oneshot, load, term_in,
        input  count, running, hit, done
`ifdef INTERVAL_TIMER_HITCNT_EN
        , input hit_count
`endif
    );

    modport slave (
        input  start, stop, clear, enable, oneshot, load, term_in,
        output count, running, hit, done
`ifdef INTERVAL_TIMER_HITCNT_EN
        , output hit_count
`endif
    );

endinterface

// File: rtl/interval_timer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk, rst_n (async, active-low), i_inc, i_clr, o_q.
// Only built when INTERVAL_TIMER_HITCNT_EN is defined.
`ifdef INTERVAL_TIMER_HITCNT_EN
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule
`endif

// File: rtl/interval_timer.sv
// Programmable interval timer: periodic/one-shot wrap at a loadable terminal.
// Ports: ck, reset_n (async, active-low), bus (interval_timer_if.slave).
// Macro INTERVAL_TIMER_HITCNT_EN adds the saturating hit_count output.
module interval_timer import timer_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PERIOD = DEF_PERIOD
`ifdef INTERVAL_TIMER_HITCNT_EN
    ,
    parameter int HCW    = DEF_HCW
`endif
) (
    input logic             ck,
    input logic             reset_n,
    interval_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] RST_TERM = WIDTH'(PERIOD - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_term;
    logic             r_mode;
    logic             r_hit;
    logic             r_done;
    logic             r_running;

    logic w_start;
    logic w_at_term;
    logic w_wrap;

    // stop beats start; start+stop outside RUN does nothing
    assign w_start   = bus.start & ~bus.stop;
    // >= so a terminal lowered below count wraps at once
    assign w_at_term = (r_count >= r_term);
    assign w_wrap    = (r_state == RUN) & ~bus.stop & ~bus.start
                     & ~bus.clear & bus.enable & w_at_term;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_term    <= RST_TERM;
            r_mode    <= 1'b0;
            r_hit     <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_hit <= w_wrap;
            if (bus.load) begin
                r_term <= bus.term_in;
            end
            if (bus.stop) begin
                if (r_state == RUN) begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
                if (bus.clear) begin
                    r_count <= '0;
                end
            end else if (bus.start) begin
                r_state   <= RUN;
                r_running <= 1'b1;
                r_count   <= '0;
                r_done    <= 1'b0;
                r_mode    <= bus.oneshot;
            end else if (bus.clear) begin
                r_count <= '0;
            end else if ((r_state == RUN) && bus.enable) begin
                if (w_at_term) begin
                    r_count <= '0;
                    if (r_mode) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.running = r_running;
    assign bus.hit     = r_hit;
    assign bus.done    = r_done;

`ifdef INTERVAL_TIMER_HITCNT_EN
    sat_counter #(
        .W     (HCW)
    ) u_hits (
        .clk   (ck),
        .rst_n (reset_n),
        .i_inc (w_wrap),
        .i_clr (w_start | bus.clear),
        .o_q   (bus.hit_count)
    );
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer with PERIOD=5, WIDTH=8 (HCW=2).
// Expected outputs are queued as stimulus is driven and popped after the edge.
module tb_interval_timer;
    import timer_pkg::*;

    localparam int W     = 8;
    localparam int P     = 5;
    localparam int HCMAX = 3;
`ifdef INTERVAL_TIMER_HITCNT_EN
    localparam int HC    = 2;
`endif

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         run;
        logic         hit;
        logic         done;
        logic [7:0]   hc;
    } exp_t;

    logic ck = 1'b0;
    logic reset_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb[$];

    int           m_st;
    logic [W-1:0] m_cnt;
    logic [W-1:0] m_term;
    bit           m_mode;
    bit           m_hit;
    bit           m_done;
    int           m_hc;

    interval_timer_if #(
        .WIDTH (W)
`ifdef INTERVAL_TIMER_HITCNT_EN
        , .HCW (HC)
`endif
    ) bus ();

    interval_timer #(
        .WIDTH   (W),
        .PERIOD  (P)
`ifdef INTERVAL_TIMER_HITCNT_EN
        , .HCW   (HC)
`endif
    ) dut (
        .ck      (ck),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_cnt  = '0;
        m_term = W'(P - 1);
        m_mode = 1'b0;
        m_hit  = 1'b0;
        m_done = 1'b0;
        m_hc   = 0;
    endtask

    task automatic step(input bit st, input bit sp, input bit cl,
                        input bit en, input bit os, input bit ld,
                        input logic [W-1:0] ti);
        exp_t e;
        bit   wrap;
        bus.start   = st;
        bus.stop    = sp;
        bus.clear   = cl;
        bus.enable  = en;
        bus.oneshot = os;
        bus.load    = ld;
        bus.term_in = ti;
        wrap = 1'b0;
        if (sp) begin
            if (m_st == 1) m_st = 0;
            if (cl) m_cnt = '0;
        end else if (st) begin
            m_st   = 1;
            m_cnt  = '0;
            m_done = 1'b0;
            m_mode = os;
        end else if (cl) begin
            m_cnt = '0;
        end else if (m_st == 1 && en) begin
            if (m_cnt >= m_term) begin
                wrap  = 1'b1;
                m_cnt = '0;
                if (m_mode) begin
                    m_st   = 2;
                    m_done = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end
        m_hit = wrap;
        if (cl || (st && !sp)) m_hc = 0;
        else if (wrap && m_hc < HCMAX) m_hc++;
        if (ld) m_term = ti;
        e.cnt  = m_cnt;
        e.run  = (m_st == 1);
        e.hit  = m_hit;
        e.done = m_done;
        e.hc   = 8'(m_hc);
        sb.push_back(e);
        @(posedge ck);
        #1;
        e = sb.pop_front();
        chk("count", 32'(bus.count), 32'(e.cnt));
        chk("running", 32'(bus.running), 32'(e.run));
        chk("hit", 32'(bus.hit), 32'(e.hit));
        chk("done", 32'(bus.done), 32'(e.done));
`ifdef INTERVAL_TIMER_HITCNT_EN
        chk("hit_count", 32'(bus.hit_count), 32'(e.hc));
`endif
    endtask

    task automatic en_step();
        step(0, 0, 0, 1, 0, 0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last;
        int nh;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.clear   = 1'b0;
        bus.enable  = 1'b0;
        bus.oneshot = 1'b0;
        bus.load    = 1'b0;
        bus.term_in = '0;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_done", 32'(bus.done), 0);
`ifdef INTERVAL_TIMER_HITCNT_EN
        chk("rst_hit_count", 32'(bus.hit_count), 0);
`endif
        @(negedge ck);
        reset_n = 1'b1;

        // periodic, reset terminal 4
        step(1, 0, 0, 1, 0, 0, '0);
        last = 0;
        nh = 0;
        for (int i = 1; i <= 20; i++) begin
            en_step();
            chk("t1_seq", 32'(bus.count), 32'(i % 5));
            if (bus.hit) begin
                chk("t1_gap", 32'(i - last), 5);
                last = i;
                nh++;
            end
        end
        chk("t1_hits", 32'(nh), 4);
        step(0, 1, 0, 1, 0, 0, '0);
        chk("t1_stop_run", 32'(bus.running), 0);

        // one-shot, terminal 3
        step(0, 0, 0, 0, 0, 1, 8'd3);
        step(1, 0, 0, 1, 1, 0, '0);
        nh = 0;
        for (int i = 1; i <= 8; i++) begin
            en_step();
            if (bus.hit) nh++;
            if (i == 4) begin
                chk("t2_hit", 32'(bus.hit), 1);
                chk("t2_done", 32'(bus.done), 1);
                chk("t2_run", 32'(bus.running), 0);
                chk("t2_cnt", 32'(bus.count), 0);
            end
        end
        chk("t2_hits", 32'(nh), 1);
        chk("t2_sticky", 32'(bus.done), 1);
        step(1, 0, 0, 1, 0, 0, '0);
        chk("t2_restart_done", 32'(bus.done), 0);
        chk("t2_restart_run", 32'(bus.running), 1);
        step(0, 1, 0, 0, 0, 0, '0);

        // pause
        step(0, 0, 0, 0, 0, 1, 8'd4);
        step(1, 0, 0, 1, 0, 0, '0);
        repeat (3) en_step();
        chk("t3_cnt3", 32'(bus.count), 3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, '0);
            chk("t3_hold", 32'(bus.count), 3);
            chk("t3_nohit", 32'(bus.hit), 0);
        end
        en_step();
        chk("t3_pre", 32'(bus.hit), 0);
        en_step();
        chk("t3_hit", 32'(bus.hit), 1);
        step(0, 1, 0, 0, 0, 0, '0);

        // load below current count
        step(0, 0, 0, 0, 0, 1, 8'd9);
        step(1, 0, 0, 1, 0, 0, '0);
        repeat (7) en_step();
        chk("t4_cnt7", 32'(bus.count), 7);
        step(0, 0, 0, 0, 0, 1, 8'd4);
        chk("t4_held", 32'(bus.count), 7);
        en_step();
        chk("t4_wrap", 32'(bus.count), 0);
        chk("t4_hit", 32'(bus.hit), 1);
        last = 0;
        for (int i = 1; i <= 10; i++) begin
            en_step();
            if (bus.hit) begin
                chk("t4_gap", 32'(i - last), 5);
                last = i;
            end
        end
        chk("t4_last", 32'(last), 10);
        step(0, 1, 0, 0, 0, 0, '0);

        // clear at the wrap, start+stop
        step(1, 0, 0, 1, 0, 0, '0);
        repeat (4) en_step();
        chk("t5_cnt4", 32'(bus.count), 4);
        step(0, 0, 1, 1, 0, 0, '0);
        chk("t5_clr_cnt", 32'(bus.count), 0);
        chk("t5_clr_nohit", 32'(bus.hit), 0);
        en_step();
        chk("t5_resume", 32'(bus.count), 1);
        step(1, 1, 0, 1, 0, 0, '0);
        chk("t5_ss_run", 32'(bus.running), 0);
        chk("t5_ss_cnt", 32'(bus.count), 1);
        step(1, 1, 0, 1, 0, 0, '0);
        chk("t5_ss_idle", 32'(bus.running), 0);

        // saturation, then async reset mid-run
        step(1, 0, 0, 1, 0, 0, '0);
        repeat (25) en_step();
`ifdef INTERVAL_TIMER_HITCNT_EN
        chk("t6_sat", 32'(bus.hit_count), 3);
        step(0, 0, 1, 1, 0, 0, '0);
        chk("t6_clr_hc", 32'(bus.hit_count), 0);
`endif
        step(0, 0, 0, 1, 0, 1, 8'd2);
        en_step();
        en_step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count), 0);
        chk("ar_running", 32'(bus.running), 0);
        chk("ar_hit", 32'(bus.hit), 0);
        chk("ar_done", 32'(bus.done), 0);
`ifdef INTERVAL_TIMER_HITCNT_EN
        chk("ar_hit_count", 32'(bus.hit_count), 0);
`endif
        model_reset();
        @(negedge ck);
        reset_n = 1'b1;
        step(1, 0, 0, 1, 0, 0, '0);
        for (int i = 1; i <= 5; i++) begin
            en_step();
            chk("ar_term", 32'(bus.hit), (i == 5) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
